decoder_arbiter: RTL

- Shares one instance of the 7-bit code decoder (decoder_proj datapath) among NREQ requesters.
- Arbitrates round-robin and issues the winning code to the decoder.
- Waits a fixed decoder latency, captures the decoded word, and returns it with the requester ID over a valid/ready response channel.
- Sits between the requester ports and the decoder core, replacing direct io_in drive of the decoder.

---
 rtl/decoder_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/decoder_arbiter.sv
// Round-robin front end that time-shares one code decoder among NREQ requesters
// and returns each decoded word, tagged with the requester index, over a valid/ready channel.
module decoder_arbiter #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 7,
    parameter int OUT_W  = 16,
    parameter int LAT    = 2,
    parameter int ID_W   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*CODE_W-1:0]   i_req_code,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [CODE_W-1:0]        o_dec_code,
    output logic                     o_dec_en,
    input  logic [OUT_W-1:0]         i_dec_out,
    output logic                     o_rsp_valid,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [OUT_W-1:0]         o_rsp_data,
    input  logic                     i_rsp_ready,
    output logic                     o_busy
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    // state  | meaning
    // S_IDLE | no decode in flight, grant offered to the round-robin winner
    // S_WAIT | code issued, counting down the decoder latency
    // S_RESP | decoded word presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_dec_code;
    logic                r_dec_en;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [OUT_W-1:0]    r_rsp_data;

    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    logic [NREQ-1:0]     w_req_ready;
    logic [ID_W-1:0]     w_rr_nxt;

    // Scan offsets from the far end down so the nearest valid requester at or
    // above rr_ptr is the last one written and therefore wins.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_grant = '0;
        v_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (i_req_valid[ID_W'(v_idx)]) begin
                w_found = 1'b1;
                w_grant = ID_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_rr_nxt = (r_rsp_id == ID_W'(NREQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_state_nxt = S_WAIT;
            S_WAIT: if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP: if (i_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_dec_code  <= '0;
            r_dec_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_dec_code <= i_req_code[w_grant*CODE_W +: CODE_W];
                        r_rsp_id   <= w_grant;
                        r_cnt      <= CNT_W'(LAT - 1);
                        r_dec_en   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= i_dec_out;
                        r_dec_en    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // Pointer moves only on completion so a stalled response keeps fairness intact.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_rr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_dec_code  = r_dec_code;
    assign o_dec_en    = r_dec_en;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);

endmodule
